load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 9 +
 rtl/load_align.sv | 15 +
 rtl/load_store_unit.sv | 120 ++++++++++++
 tb/tb_load_store_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states, counter width and misalignment check shared by the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_X = 2'd3} size_e;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  localparam int CNT_W = 4;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_X || (size == SZ_H && off[0]) || (size == SZ_W && off != 2'd0);
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: shifts a read word down by byte offset then sign/zero-extends per size (rdata_i, offset_i, size_i, uns_i -> result_o)
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] result_o
);
  logic [31:0] sh;
  assign sh = rdata_i >> {offset_i, 3'b000};
  assign result_o = size_i == SZ_B ? {{24{~uns_i & sh[7]}}, sh[7:0]} :
                    size_i == SZ_H ? {{16{~uns_i & sh[15]}}, sh[15:0]} : sh;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-outstanding load/store FSM; in_* request handshake, mem_* word-aligned memory port held MEM_LAT cycles, out_* response handshake
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_err,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, aligned;
  logic [1:0]        off_q, off_d, size_q, size_d;
  logic [7:0]        wmask_q, wmask_d;
  logic [4:0]        rd_q, rd_d;
  logic              uns_q, uns_d, wen_q, wen_d, err_q, err_d, st;
  logic [3:0]        mask4;

  load_align u_align (.rdata_i(mem_rdata), .offset_i(off_q), .size_i(size_q), .uns_i(uns_q), .result_o(aligned));

  assign mask4 = in_size == SZ_B ? 4'b0001 : in_size == SZ_H ? 4'b0011 : 4'b1111;
  assign st    = in_wen && !misaligned(in_size, in_addr[1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    if (in_valid && in_ready) begin
      err_d   = misaligned(in_size, in_addr[1:0]);
      state_d = err_d ? RESP : ACCESS;
      cnt_d   = CNT_W'(MEM_LAT - 1);
      addr_d  = {in_addr[31:2], 2'b00};
      off_d   = in_addr[1:0];
      size_d  = in_size;
      uns_d   = in_unsigned;
      rd_d    = in_rd;
      wen_d   = in_wen;
      wmask_d = st ? {4'b0000, mask4 << in_addr[1:0]} : 8'h00;
      wdata_d = st ? in_wdata << {in_addr[1:0], 3'b000} : 32'h0;
      rdata_d = 32'h0;
    end else if (state_q == ACCESS) begin
      cnt_d   = cnt_q == '0 ? '0 : cnt_q - 1'b1;
      state_d = cnt_q == '0 ? RESP : ACCESS;
      rdata_d = cnt_q == '0 && !wen_q ? aligned : rdata_q;
    end else if (state_q == RESP && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end

  assign in_ready  = state_q == IDLE && !rst;
  assign mem_valid = state_q == ACCESS;
  assign mem_wen   = mem_valid && wen_q && cnt_q == '0;
  assign mem_raddr = addr_q;
  assign mem_waddr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign out_valid = state_q == RESP;
  assign out_rdata = rdata_q;
  assign out_rd    = rd_q;
  assign out_err   = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit at MEM_LAT=1 (u1) and MEM_LAT=3 (u3)
module tb_load_store_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_wen = 1'b0, in_uns = 1'b0, iv1 = 1'b0, iv3 = 1'b0, rdy1 = 1'b1, rdy3 = 1'b1;
  logic [31:0] in_addr = '0, in_wdata = '0, mem_rdata = '0;
  logic [1:0]  in_size = '0;
  logic [4:0]  in_rd = '0;
  logic        ir1, ov1, err1, mv1, mw1, ir3, ov3, err3, mv3, mw3;
  logic [31:0] rdata1, ra1, wa1, wd1, rdata3, ra3, wa3, wd3;
  logic [4:0]  ord1, ord3;
  logic [7:0]  wm1, wm3;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_wen(in_wen), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_size(in_size), .in_unsigned(in_uns), .in_rd(in_rd),
    .out_valid(ov1), .out_ready(rdy1), .out_rdata(rdata1), .out_rd(ord1), .out_err(err1),
    .mem_valid(mv1), .mem_wen(mw1), .mem_raddr(ra1), .mem_waddr(wa1), .mem_wdata(wd1),
    .mem_wmask(wm1), .mem_rdata(mem_rdata)
  );

  load_store_unit #(.MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_wen(in_wen), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_size(in_size), .in_unsigned(in_uns), .in_rd(in_rd),
    .out_valid(ov3), .out_ready(rdy3), .out_rdata(rdata3), .out_rd(ord3), .out_err(err3),
    .mem_valid(mv3), .mem_wen(mw3), .mem_raddr(ra3), .mem_waddr(wa3), .mem_wdata(wd3),
    .mem_wmask(wm3), .mem_rdata(mem_rdata)
  );

  task automatic drive(input logic w, input logic [31:0] a, input logic [1:0] sz, input logic u,
                       input logic [31:0] wd, input logic [4:0] rd);
    in_wen = w; in_addr = a; in_size = sz; in_uns = u; in_wdata = wd; in_rd = rd;
  endtask

  task automatic test_reset;
    #2;
    n_chk++; if (ir1 !== 1'b0) begin n_fail++; $display("FAIL rst_ready1 got %b want 0", ir1); end
    n_chk++; if ({ov1, mv1, mw1, err1} !== 4'b0) begin n_fail++; $display("FAIL rst_outs1 got %b want 0000", {ov1, mv1, mw1, err1}); end
    n_chk++; if (ir3 !== 1'b0) begin n_fail++; $display("FAIL rst_ready3 got %b want 0", ir3); end
    @(negedge clk); rst = 1'b0; #1;
    n_chk++; if (ir1 !== 1'b1) begin n_fail++; $display("FAIL rel_ready1 got %b want 1", ir1); end
    n_chk++; if (ir3 !== 1'b1) begin n_fail++; $display("FAIL rel_ready3 got %b want 1", ir3); end
  endtask

  task automatic test_load_word;
    @(negedge clk); drive(1'b0, 32'h80000004, 2'd2, 1'b0, 32'h0, 5'd5); mem_rdata = 32'hDEADBEEF; iv1 = 1'b1;
    @(negedge clk); iv1 = 1'b0;
    n_chk++; if ({mv1, ov1, ir1, mw1} !== 4'b1000) begin n_fail++; $display("FAIL lw_access got %b want 1000", {mv1, ov1, ir1, mw1}); end
    n_chk++; if (ra1 !== 32'h80000004) begin n_fail++; $display("FAIL lw_raddr got %h want 80000004", ra1); end
    n_chk++; if (wm1 !== 8'h00 || wd1 !== 32'h0) begin n_fail++; $display("FAIL lw_wmask got %h/%h want 00/0", wm1, wd1); end
    @(negedge clk);
    n_chk++; if (ov1 !== 1'b1) begin n_fail++; $display("FAIL lw_valid got %b want 1", ov1); end
    n_chk++; if (rdata1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata got %h want deadbeef", rdata1); end
    n_chk++; if (ord1 !== 5'd5 || err1 !== 1'b0) begin n_fail++; $display("FAIL lw_tag got %0d/%b want 5/0", ord1, err1); end
    @(negedge clk);
    n_chk++; if (ov1 !== 1'b0 || ir1 !== 1'b1) begin n_fail++; $display("FAIL lw_done got %b%b want 01", ov1, ir1); end
  endtask

  task automatic test_load_byte;
    for (int u = 0; u < 2; u++) begin
      @(negedge clk); drive(1'b0, 32'h80000003, 2'd0, u[0], 32'h0, 5'd7); mem_rdata = 32'h80112233; iv1 = 1'b1;
      @(negedge clk); iv1 = 1'b0;
      @(negedge clk);
      n_chk++; if (rdata1 !== (u == 1 ? 32'h00000080 : 32'hFFFFFF80)) begin n_fail++; $display("FAIL lb_u%0d got %h want %h", u, rdata1, u == 1 ? 32'h80 : 32'hFFFFFF80); end
    end
    @(negedge clk);
  endtask

  task automatic test_store_half;
    int pulses = 0;
    @(negedge clk); drive(1'b1, 32'h80000002, 2'd1, 1'b0, 32'h0000ABCD, 5'd3); iv1 = 1'b1;
    @(negedge clk); iv1 = 1'b0; pulses += int'(mw1);
    n_chk++; if (mw1 !== 1'b1) begin n_fail++; $display("FAIL sh_wen got %b want 1", mw1); end
    n_chk++; if (wa1 !== 32'h80000000) begin n_fail++; $display("FAIL sh_waddr got %h want 80000000", wa1); end
    n_chk++; if (wm1 !== 8'h0C) begin n_fail++; $display("FAIL sh_wmask got %h want 0c", wm1); end
    n_chk++; if (wd1 !== 32'hABCD0000) begin n_fail++; $display("FAIL sh_wdata got %h want abcd0000", wd1); end
    @(negedge clk); pulses += int'(mw1);
    n_chk++; if (ov1 !== 1'b1 || rdata1 !== 32'h0) begin n_fail++; $display("FAIL sh_resp got %b/%h want 1/0", ov1, rdata1); end
    @(negedge clk); pulses += int'(mw1);
    n_chk++; if (pulses != 1) begin n_fail++; $display("FAIL sh_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_misaligned;
    logic seen = 1'b0;
    @(negedge clk); drive(1'b0, 32'h80000001, 2'd2, 1'b0, 32'h0, 5'd9); mem_rdata = 32'hFFFFFFFF; iv1 = 1'b1;
    @(negedge clk); iv1 = 1'b0; seen |= mv1;
    n_chk++; if ({ov1, err1} !== 2'b11) begin n_fail++; $display("FAIL mis_err got %b want 11", {ov1, err1}); end
    n_chk++; if (rdata1 !== 32'h0 || ord1 !== 5'd9) begin n_fail++; $display("FAIL mis_data got %h/%0d want 0/9", rdata1, ord1); end
    @(negedge clk); seen |= mv1;
    n_chk++; if (ir1 !== 1'b1 || ov1 !== 1'b0) begin n_fail++; $display("FAIL mis_idle got %b%b want 10", ir1, ov1); end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mis_memvalid got %b want 0", seen); end
  endtask

  task automatic test_store_lat3;
    @(negedge clk); drive(1'b1, 32'h80000001, 2'd0, 1'b0, 32'h0000005A, 5'd2); iv3 = 1'b1;
    @(negedge clk); iv3 = 1'b0;
    n_chk++; if ({mv3, mw3} !== 2'b10) begin n_fail++; $display("FAIL sb3_c1 got %b want 10", {mv3, mw3}); end
    @(negedge clk);
    n_chk++; if ({mv3, mw3} !== 2'b10) begin n_fail++; $display("FAIL sb3_c2 got %b want 10", {mv3, mw3}); end
    @(negedge clk);
    n_chk++; if ({mv3, mw3, wm3} !== {2'b11, 8'h02}) begin n_fail++; $display("FAIL sb3_c3 got %b%b/%h want 11/02", mv3, mw3, wm3); end
    n_chk++; if (wd3 !== 32'h00005A00) begin n_fail++; $display("FAIL sb3_wdata got %h want 00005a00", wd3); end
    @(negedge clk);
    n_chk++; if ({ov3, mw3, mv3} !== 3'b100) begin n_fail++; $display("FAIL sb3_resp got %b want 100", {ov3, mw3, mv3}); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    logic seen = 1'b0;
    @(negedge clk); drive(1'b1, 32'h80000010, 2'd2, 1'b0, 32'h12345678, 5'd1); iv3 = 1'b1;
    @(negedge clk); iv3 = 1'b0;
    @(negedge clk);
    n_chk++; if ({mv3, mw3} !== 2'b10) begin n_fail++; $display("FAIL ab_c2 got %b want 10", {mv3, mw3}); end
    rst = 1'b1; #1;
    n_chk++; if ({mv3, mw3, ir3, ov3} !== 4'b0) begin n_fail++; $display("FAIL ab_async got %b want 0000", {mv3, mw3, ir3, ov3}); end
    repeat (2) begin @(negedge clk); seen |= mw3 | ov3; end
    rst = 1'b0; #1;
    n_chk++; if (ir3 !== 1'b1) begin n_fail++; $display("FAIL ab_ready got %b want 1", ir3); end
    drive(1'b0, 32'h80000020, 2'd2, 1'b0, 32'h0, 5'd4); mem_rdata = 32'h00001234; iv3 = 1'b1;
    @(negedge clk); iv3 = 1'b0; seen |= mw3;
    n_chk++; if (mv3 !== 1'b1 || ra3 !== 32'h80000020) begin n_fail++; $display("FAIL ab_accept got %b/%h want 1/80000020", mv3, ra3); end
    @(negedge clk); seen |= mw3;
    @(negedge clk); seen |= mw3;
    n_chk++; if (ov3 !== 1'b0) begin n_fail++; $display("FAIL lw3_early got %b want 0", ov3); end
    @(negedge clk);
    n_chk++; if (ov3 !== 1'b1 || rdata3 !== 32'h00001234 || ord3 !== 5'd4) begin n_fail++; $display("FAIL lw3_resp got %b/%h/%0d want 1/00001234/4", ov3, rdata3, ord3); end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL ab_nowrite got %b want 0", seen); end
    @(negedge clk);
  endtask

  task automatic test_stall;
    rdy1 = 1'b0;
    @(negedge clk); drive(1'b0, 32'h80000002, 2'd1, 1'b0, 32'h0, 5'd12); mem_rdata = 32'h80010000; iv1 = 1'b1;
    @(negedge clk); iv1 = 1'b0;
    @(negedge clk);
    n_chk++; if (ov1 !== 1'b1 || rdata1 !== 32'hFFFF8001) begin n_fail++; $display("FAIL st_first got %b/%h want 1/ffff8001", ov1, rdata1); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++; if ({ov1, ir1, mv1} !== 3'b100 || rdata1 !== 32'hFFFF8001 || ord1 !== 5'd12) begin
        n_fail++; $display("FAIL st_hold%0d got %b/%h/%0d want 100/ffff8001/12", i, {ov1, ir1, mv1}, rdata1, ord1);
      end
      drive(1'b1, 32'h00000040, 2'd2, 1'b0, 32'hFFFFFFFF, 5'd1); mem_rdata = 32'h0; iv1 = (i % 2 == 0);
    end
    @(negedge clk); iv1 = 1'b0; rdy1 = 1'b1;
    @(negedge clk);
    n_chk++; if ({ov1, ir1, mv1} !== 3'b010) begin n_fail++; $display("FAIL st_release got %b want 010", {ov1, ir1, mv1}); end
  endtask

  initial begin
    test_reset;
    test_load_word;
    test_load_byte;
    test_store_half;
    test_misaligned;
    test_store_lat3;
    test_reset_abort;
    test_stall;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
